// File: rtl/vc_squash_queue.sv
// Squashable response queue: circular buffer with a single-cycle flush.
// Optional combinational bypass when empty: define VC_SQUASH_QUEUE_BYPASS_EN.
module vc_squash_queue #(
  parameter int p_msg_nbits   = 1,
  parameter int p_num_entries = 2
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_domain,
  input  logic                           i_squash,
  input  logic [p_msg_nbits-1:0]         i_enq_msg,
  input  logic                           i_enq_val,
  output logic                           o_enq_rdy,
  output logic [p_msg_nbits-1:0]         o_deq_msg,
  output logic                           o_deq_val,
  input  logic                           i_deq_rdy,
  output logic [$clog2(p_num_entries):0] o_num_free_entries
);

  localparam int PW = $clog2(p_num_entries);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(p_num_entries);

  logic [p_msg_nbits-1:0] r_mem [p_num_entries];
  logic [PW-1:0]          r_enq_ptr;
  logic [PW-1:0]          r_deq_ptr;
  logic [CW-1:0]          r_count;

  logic [PW-1:0]          w_enq_ptr_nxt;
  logic [PW-1:0]          w_deq_ptr_nxt;
  logic [CW-1:0]          w_count_nxt;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_enq_go;
  logic                   w_deq_go;
  logic                   w_unused_domain;

  // domain is a label only; it never steers behaviour
  assign w_unused_domain = i_domain;

  assign w_full  = (r_count == DEPTH);
  assign w_empty = (r_count == '0);

  assign o_enq_rdy          = !w_full;
  assign o_num_free_entries = DEPTH - r_count;

`ifdef VC_SQUASH_QUEUE_BYPASS_EN
  // An empty queue forwards the offered message; if it is taken now, storage is untouched
  assign o_deq_val = !i_squash && (!w_empty || i_enq_val);
  assign o_deq_msg = w_empty ? i_enq_msg : r_mem[r_deq_ptr];
  assign w_enq_go  = i_enq_val && !w_full && !i_squash && !(w_empty && i_deq_rdy);
  assign w_deq_go  = o_deq_val && i_deq_rdy && !w_empty;
`else
  assign o_deq_val = !w_empty && !i_squash;
  assign o_deq_msg = r_mem[r_deq_ptr];
  assign w_enq_go  = i_enq_val && !w_full && !i_squash;
  assign w_deq_go  = o_deq_val && i_deq_rdy;
`endif

  always_comb begin
    w_enq_ptr_nxt = r_enq_ptr;
    w_deq_ptr_nxt = r_deq_ptr;
    w_count_nxt   = r_count;
    if (i_squash) begin
      w_enq_ptr_nxt = '0;
      w_deq_ptr_nxt = '0;
      w_count_nxt   = '0;
    end else begin
      if (w_enq_go) w_enq_ptr_nxt = r_enq_ptr + PW'(1);
      if (w_deq_go) w_deq_ptr_nxt = r_deq_ptr + PW'(1);
      case ({w_enq_go, w_deq_go})
        2'b10:   w_count_nxt = r_count + CW'(1);
        2'b01:   w_count_nxt = r_count - CW'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_enq_ptr <= '0;
      r_deq_ptr <= '0;
      r_count   <= '0;
    end else begin
      r_enq_ptr <= w_enq_ptr_nxt;
      r_deq_ptr <= w_deq_ptr_nxt;
      r_count   <= w_count_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_enq_go) r_mem[r_enq_ptr] <= i_enq_msg;
  end

endmodule

// File: tb/tb_vc_squash_queue.sv
// Randomized bench for vc_squash_queue against a queue-based reference model.
module tb_vc_squash_queue;

  localparam int DEPTH = 4;
  localparam int MW    = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset, domain, squash, enq_val, deq_rdy;
  logic [MW-1:0] enq_msg;
  logic          enq_rdy, deq_val;
  logic [MW-1:0] deq_msg;
  logic [CW-1:0] num_free;

  int n_vec = 0;
  int n_err = 0;
  logic [MW-1:0] model_q[$];

  always #5 clk = ~clk;

  vc_squash_queue #(.p_msg_nbits(MW), .p_num_entries(DEPTH)) dut (
    .i_clk              (clk),
    .i_reset            (reset),
    .i_domain           (domain),
    .i_squash           (squash),
    .i_enq_msg          (enq_msg),
    .i_enq_val          (enq_val),
    .o_enq_rdy          (enq_rdy),
    .o_deq_msg          (deq_msg),
    .o_deq_val          (deq_val),
    .i_deq_rdy          (deq_rdy),
    .o_num_free_entries (num_free)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, check outputs mid-cycle, then advance the model at the edge.
  task automatic step(input logic rst, input logic sq, input logic ev,
                      input logic [MW-1:0] msg, input logic dr);
    bit exp_val, exp_rdy, bypass, do_enq, do_deq;
    logic [MW-1:0] exp_msg;
    @(negedge clk);
    reset = rst; squash = sq; enq_val = ev; enq_msg = msg; deq_rdy = dr;
    domain = 1'($urandom_range(0, 1));
    #1;
    exp_rdy = (model_q.size() < DEPTH);
    bypass  = 1'b0;
`ifdef VC_SQUASH_QUEUE_BYPASS_EN
    bypass  = (model_q.size() == 0) && !sq && ev;
`endif
    exp_val = !sq && (model_q.size() > 0 || bypass);
    exp_msg = (model_q.size() > 0) ? model_q[0] : msg;
    chk("enq_rdy", 32'(enq_rdy), 32'(exp_rdy));
    chk("deq_val", 32'(deq_val), 32'(exp_val));
    chk("num_free", 32'(num_free), 32'(DEPTH - model_q.size()));
    if (exp_val) chk("deq_msg", 32'(deq_msg), 32'(exp_msg));
    @(posedge clk);
    if (rst || sq) begin
      model_q.delete();
    end else if (bypass && dr) begin
      // consumed straight through; nothing stored
    end else begin
      do_deq = exp_val && dr;
      do_enq = ev && exp_rdy;
      if (do_deq) void'(model_q.pop_front());
      if (do_enq) model_q.push_back(msg);
    end
  endtask

  initial begin
    reset = 1'b1; squash = 1'b0; enq_val = 1'b0; deq_rdy = 1'b0;
    enq_msg = '0; domain = 1'b0;
    repeat (2) @(posedge clk);
    model_q.delete();

    // idle after reset
    step(0, 0, 0, 8'h00, 0);
    // fill to full, refusal while full and dequeuing, drain
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 8'hA0 + 8'(i), 0);
    step(0, 0, 1, 8'hEE, 1);
    step(0, 0, 1, 8'hEF, 0);
    for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 0, 8'h00, 1);
    // streaming 0..9 with consumer always ready
    for (int i = 0; i < 10; i++) step(0, 0, 1, 8'(i), 1);
    step(0, 0, 0, 8'h00, 1);
    // squash with a same-cycle enqueue of 0xC
    step(0, 0, 1, 8'h0A, 0);
    step(0, 0, 1, 8'h0B, 0);
    step(0, 1, 1, 8'h0C, 1);
    step(0, 0, 0, 8'h00, 1);
    // multi-cycle squash
    step(0, 0, 1, 8'h11, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 8'h22, 1);
    step(0, 0, 0, 8'h00, 1);
    // reset mid-operation with three entries held
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h30 + 8'(i), 0);
    step(1, 0, 1, 8'h3F, 1);
    step(0, 0, 0, 8'h00, 1);
    step(0, 0, 0, 8'h00, 1);
    // empty queue, offer with consumer ready
    step(0, 0, 1, 8'h05, 1);
    step(0, 0, 0, 8'h00, 1);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 9) < 7),
           8'($urandom),
           ($urandom_range(0, 9) < (i % 200 < 100 ? 3 : 8)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
